// File: rtl/scrambler_frame_ctrl.sv
// Frames payload words into a serial bitstream: fixed preamble, then payload scrambled by a reseeded
// x^12+x^9+x^2+1 self-sync LFSR. Define SCR_FRAME_PARITY_EN to append an even-parity bit per frame.
`timescale 1ns/1ps

module scrambler_frame_ctrl #(
   parameter int               DATA_W      = 8,
   parameter int               PRE_W       = 16,
   parameter logic [PRE_W-1:0] PRE_PATTERN = 16'hF0F0,
   parameter logic [11:0]      SEED        = 12'hABC,
   parameter int               GAP_CYCLES  = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_valid_i,
   input  logic              s_last_i,
   output logic              s_ready_o,
   output logic              ser_data_o,
   output logic              ser_valid_o,
   output logic              ser_sof_o,
   output logic              ser_eof_o,
   output logic              busy_o
);

   localparam int PCW = (PRE_W > 1) ? $clog2(PRE_W) : 1;
   localparam int DCW = $clog2(DATA_W);
   localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [PCW-1:0] PRE_LAST = PCW'(PRE_W - 1);
   localparam logic [DCW-1:0] BIT_LAST = DCW'(DATA_W - 1);
   localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);

`ifdef SCR_FRAME_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_PAY, ST_WAIT, ST_PAR, ST_GAP} state_t;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_PAY, ST_WAIT, ST_GAP} state_t;
`endif

   state_t            state_q, state_d;
   logic [PCW-1:0]    pre_cnt_q, pre_cnt_d;
   logic [DCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GCW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              last_q, last_d;
   logic [11:0]       lfsr_q, lfsr_d;
   logic              ser_data_q, ser_data_d;
   logic              ser_valid_q, ser_valid_d;
   logic              ser_sof_q, ser_sof_d;
   logic              ser_eof_q, ser_eof_d;
   logic              ready_c;
   logic              fb;
`ifdef SCR_FRAME_PARITY_EN
   logic              par_q, par_d;
`endif

   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      shreg_d     = shreg_q;
      last_d      = last_q;
      lfsr_d      = lfsr_q;
      ser_data_d  = 1'b0;
      ser_valid_d = 1'b0;
      ser_sof_d   = 1'b0;
      ser_eof_d   = 1'b0;
      ready_c     = 1'b0;
      fb          = shreg_q[DATA_W-1] ^ lfsr_q[11] ^ lfsr_q[8] ^ lfsr_q[1];
`ifdef SCR_FRAME_PARITY_EN
      par_d       = par_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            ready_c = 1'b1;
            if (s_valid_i && !rst_i) begin
               shreg_d   = s_data_i;
               last_d    = s_last_i;
               lfsr_d    = SEED;
               pre_cnt_d = '0;
               state_d   = ST_PRE;
`ifdef SCR_FRAME_PARITY_EN
               par_d     = 1'b0;
`endif
            end
         end
         ST_PRE: begin
            ser_valid_d = 1'b1;
            ser_data_d  = PRE_PATTERN[PRE_LAST - pre_cnt_q];
            ser_sof_d   = (pre_cnt_q == '0);
            if (pre_cnt_q == PRE_LAST) begin
               pre_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = ST_PAY;
            end else begin
               pre_cnt_d = pre_cnt_q + PCW'(1);
            end
         end
         ST_PAY: begin
            ser_valid_d = 1'b1;
            ser_data_d  = fb;
            lfsr_d      = {lfsr_q[10:0], fb};
            shreg_d     = {shreg_q[DATA_W-2:0], 1'b0};
`ifdef SCR_FRAME_PARITY_EN
            par_d       = par_q ^ shreg_q[DATA_W-1];
`endif
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               if (last_q) begin
`ifdef SCR_FRAME_PARITY_EN
                  state_d   = ST_PAR;
`else
                  ser_eof_d = 1'b1;
                  gap_cnt_d = '0;
                  state_d   = ST_GAP;
`endif
               end else begin
                  // Offer the next word on the final bit so a waiting source sees no bubble
                  ready_c = 1'b1;
                  if (s_valid_i && !rst_i) begin
                     shreg_d = s_data_i;
                     last_d  = s_last_i;
                  end else begin
                     state_d = ST_WAIT;
                  end
               end
            end else begin
               bit_cnt_d = bit_cnt_q + DCW'(1);
            end
         end
         ST_WAIT: begin
            ready_c = 1'b1;
            if (s_valid_i && !rst_i) begin
               shreg_d   = s_data_i;
               last_d    = s_last_i;
               bit_cnt_d = '0;
               state_d   = ST_PAY;
            end
         end
`ifdef SCR_FRAME_PARITY_EN
         ST_PAR: begin
            ser_valid_d = 1'b1;
            ser_eof_d   = 1'b1;
            ser_data_d  = par_q;
            gap_cnt_d   = '0;
            state_d     = ST_GAP;
         end
`endif
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               state_d   = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GCW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset abandons any frame in flight; the held word is simply never shifted out
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         pre_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         shreg_q     <= '0;
         last_q      <= 1'b0;
         lfsr_q      <= SEED;
         ser_data_q  <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_sof_q   <= 1'b0;
         ser_eof_q   <= 1'b0;
`ifdef SCR_FRAME_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pre_cnt_q   <= pre_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         shreg_q     <= shreg_d;
         last_q      <= last_d;
         lfsr_q      <= lfsr_d;
         ser_data_q  <= ser_data_d;
         ser_valid_q <= ser_valid_d;
         ser_sof_q   <= ser_sof_d;
         ser_eof_q   <= ser_eof_d;
`ifdef SCR_FRAME_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign s_ready_o   = ready_c & ~rst_i;
   assign ser_data_o  = ser_data_q;
   assign ser_valid_o = ser_valid_q;
   assign ser_sof_o   = ser_sof_q;
   assign ser_eof_o   = ser_eof_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// Self-checking bench for scrambler_frame_ctrl: frame-level model of the serial stream plus
// directed scenarios (single word, multi-word, underrun, back-to-back, reset abort, parity).
`timescale 1ns/1ps

module tb_scrambler_frame_ctrl;

   localparam int          DATA_W      = 8;
   localparam int          PRE_W       = 16;
   localparam logic [15:0] PRE_PATTERN = 16'hF0F0;
   localparam logic [11:0] SEED        = 12'hABC;
   localparam int          GAP_CYCLES  = 2;
`ifdef SCR_FRAME_PARITY_EN
   localparam int          PAR_EN      = 1;
`else
   localparam int          PAR_EN      = 0;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic       ser_data;
   logic       ser_valid;
   logic       ser_sof;
   logic       ser_eof;
   logic       busy;

   scrambler_frame_ctrl #(
      .DATA_W(DATA_W), .PRE_W(PRE_W), .PRE_PATTERN(PRE_PATTERN),
      .SEED(SEED), .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
      .s_ready_o(s_ready), .ser_data_o(ser_data), .ser_valid_o(ser_valid),
      .ser_sof_o(ser_sof), .ser_eof_o(ser_eof), .busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {logic d; logic sof; logic eof;} serbit_t;
   typedef struct packed {logic valid; logic d; logic sof; logic eof; logic ready; logic busy;} sample_t;

   serbit_t     expQ[$];
   sample_t     logQ[$];
   logic        logOn;
   int          checkCount = 0;
   int          passCount  = 0;

   // Results of the last analyzeLog call
   logic [63:0] vBits;
   int          vCnt, eofPos, eofCnt, sofPos, sofCnt, payHoles, holePos;
   int          readyPulses, gapBetween, gapAfter;
   logic        riseFound;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Frame model: preamble bits, then each payload bit pushed through the self-sync scrambler
   function automatic void expectFrame(input logic [31:0] words, input int n);
      logic [11:0] l;
      logic [15:0] pat;
      logic [7:0]  w;
      logic        d, fb, par;
      serbit_t     e;
      l   = SEED;
      pat = PRE_PATTERN;
      par = 1'b0;
      for (int i = 0; i < PRE_W; i++) begin
         e.d = pat[PRE_W-1-i]; e.sof = (i == 0); e.eof = 1'b0;
         expQ.push_back(e);
      end
      for (int k = 0; k < n; k++) begin
         w = words[31-8*k -: 8];
         for (int b = 7; b >= 0; b--) begin
            d   = w[b];
            par = par ^ d;
            fb  = d ^ l[11] ^ l[8] ^ l[1];
            l   = {l[10:0], fb};
            e.d = fb; e.sof = 1'b0; e.eof = (PAR_EN == 0) && (k == n - 1) && (b == 0);
            expQ.push_back(e);
         end
      end
      if (PAR_EN != 0) begin
         e.d = par; e.sof = 1'b0; e.eof = 1'b1;
         expQ.push_back(e);
      end
   endfunction

   // Receiver-side descrambler: shifts in the received bit, independent of the transmit form
   function automatic logic [23:0] descramble24(input logic [23:0] s);
      logic [11:0] l;
      logic [23:0] out;
      l   = SEED;
      out = '0;
      for (int i = 23; i >= 0; i--) begin
         out = {out[22:0], s[i] ^ l[11] ^ l[8] ^ l[1]};
         l   = {l[10:0], s[i]};
      end
      return out;
   endfunction

   // Compare process: every valid bit against the model, flags quiet otherwise
   always @(negedge clk) begin
      serbit_t e;
      if (logOn) logQ.push_back({ser_valid, ser_data, ser_sof, ser_eof, s_ready, busy});
      if (ser_valid) begin
         if (expQ.size() == 0) checkOutput("serbit_extra", {31'd0, ser_valid}, 32'd0);
         else begin
            e = expQ.pop_front();
            checkOutput("serbit", {29'd0, ser_data, ser_sof, ser_eof}, {29'd0, e.d, e.sof, e.eof});
         end
      end else begin
         checkOutput("idle_flags", {30'd0, ser_sof, ser_eof}, 32'd0);
      end
      if (rst) expQ.delete();
   end

   task automatic analyzeLog();
      int total, seen, lastEof, lastValid;
      sample_t s;
      total = 0; seen = 0; lastEof = -1; lastValid = -1;
      vBits = '0; vCnt = 0; eofPos = -1; eofCnt = 0; sofPos = -1; sofCnt = 0;
      payHoles = 0; holePos = -1; readyPulses = 0; gapBetween = -1; gapAfter = 0; riseFound = 1'b0;
      foreach (logQ[i]) if (logQ[i].valid) total++;
      foreach (logQ[i]) begin
         s = logQ[i];
         if (s.ready && s.busy) readyPulses++;
         if (s.valid) begin
            if (s.sof) begin
               sofCnt++;
               if (sofPos < 0) sofPos = seen;
               if (lastEof >= 0 && gapBetween < 0) gapBetween = i - lastEof - 1;
            end
            if (s.eof) begin
               eofCnt++; eofPos = seen; lastEof = i;
            end
            vBits = {vBits[62:0], s.d};
            seen++;
            lastValid = i;
         end else if (seen > PRE_W && seen < total) begin
            payHoles++;
            if (holePos < 0) holePos = seen;
         end
      end
      for (int j = lastValid + 1; j < logQ.size(); j++) begin
         if (!logQ[j].valid) gapAfter++;
         if (logQ[j].ready && !logQ[j].busy) begin
            riseFound = 1'b1;
            break;
         end
      end
      vCnt = total;
   endtask

   // Source side: one word per handshake; optional stall before word holdWord
   task automatic applyStimulus(input logic [31:0] words, input int n, input int holdWord, input int holdCycles);
      int t;
      for (int k = 0; k < n; k++) begin
         if (k == holdWord && holdCycles > 0) begin
            s_valid = 1'b0;
            t = 0;
            while (!(s_ready && busy) && t < 200) begin
               @(negedge clk);
               t++;
            end
            if (t >= 200) checkOutput("hold_timeout", {31'd0, s_ready}, 32'd1);
            repeat (holdCycles) @(negedge clk);
         end
         s_data  = words[31-8*k -: 8];
         s_last  = (k == n - 1);
         s_valid = 1'b1;
         t = 0;
         while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         if (t >= 200) checkOutput("accept_timeout", {31'd0, s_ready}, 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic waitIdle();
      int t;
      t = 0;
      while ((busy || expQ.size() != 0) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
      checkOutput("exp_drained", expQ.size(), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic runFrame(input logic [31:0] words, input int n, input int holdWord, input int holdCycles);
      logQ.delete();
      logOn = 1'b1;
      expectFrame(words, n);
      applyStimulus(words, n, holdWord, holdCycles);
      waitIdle();
      logOn = 1'b0;
      analyzeLog();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] refA5, refUnder, pay;
      int          refA5Cnt, refUnderCnt;
      logic [7:0]  ref34;

      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; logOn = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", {31'd0, s_ready}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_ser", {28'd0, ser_data, ser_valid, ser_sof, ser_eof}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_ready", {31'd0, s_ready}, 32'd1);

      $display("[TB] single word A5");
      runFrame(32'hA5000000, 1, -1, 0);
      pay = vBits >> PAR_EN;
      checkOutput("t1_len", vCnt, PRE_W + 8 + PAR_EN);
      checkOutput("t1_pre", 32'(vBits >> (8 + PAR_EN)) & 32'hFFFF, 32'h0000F0F0);
      checkOutput("t1_sof_cnt", sofCnt, 32'd1);
      checkOutput("t1_sof_pos", sofPos, 32'd0);
      checkOutput("t1_payload", {24'd0, pay[7:0]}, 32'h40);
      checkOutput("t1_eof_pos", eofPos, PRE_W + 7 + PAR_EN);
      checkOutput("t1_eof_cnt", eofCnt, 32'd1);
      checkOutput("t1_ready_rise", {31'd0, riseFound}, 32'd1);
      checkOutput("t1_gap_ok", {31'd0, (gapAfter >= GAP_CYCLES)}, 32'd1);
      refA5 = vBits; refA5Cnt = vCnt;

      $display("[TB] three words 00 FF 3C");
      runFrame(32'h00FF3C00, 3, -1, 0);
      pay = vBits >> PAR_EN;
      checkOutput("t2_len", vCnt, PRE_W + 24 + PAR_EN);
      checkOutput("t2_holes", payHoles, 32'd0);
      checkOutput("t2_ready_pulses", readyPulses, 32'd2);
      checkOutput("t2_first_byte", {24'd0, pay[23:16]}, 32'hC4);
      checkOutput("t2_descramble", {8'd0, descramble24(pay[23:0])}, 32'h0000FF3C);

      $display("[TB] underrun");
      runFrame(32'h5AC30000, 2, -1, 0);
      refUnder = vBits; refUnderCnt = vCnt;
      runFrame(32'h5AC30000, 2, 1, 5);
      checkOutput("t3_holes", payHoles, 32'd5);
      checkOutput("t3_hole_pos", holePos, PRE_W + 8);
      checkOutput("t3_len", vCnt, refUnderCnt);
      checkOutput("t3_bits_lo", vBits[31:0], refUnder[31:0]);
      checkOutput("t3_bits_hi", vBits[63:32], refUnder[63:32]);

      $display("[TB] back-to-back frames");
      runFrame(32'h34000000, 1, -1, 0);
      pay = vBits >> PAR_EN;
      ref34 = pay[7:0];
      logQ.delete();
      logOn = 1'b1;
      expectFrame(32'h12000000, 1);
      expectFrame(32'h34000000, 1);
      applyStimulus(32'h12000000, 1, -1, 0);
      applyStimulus(32'h34000000, 1, -1, 0);
      waitIdle();
      logOn = 1'b0;
      analyzeLog();
      pay = vBits >> PAR_EN;
      checkOutput("t4_len", vCnt, 2 * (PRE_W + 8 + PAR_EN));
      checkOutput("t4_sof_cnt", sofCnt, 32'd2);
      checkOutput("t4_frame2", {24'd0, pay[7:0]}, {24'd0, ref34});
      checkOutput("t4_gap_ok", {31'd0, (gapBetween >= GAP_CYCLES + 1)}, 32'd1);

      $display("[TB] reset mid-payload");
      logQ.delete();
      logOn = 1'b1;
      expectFrame(32'hA5000000, 1);
      applyStimulus(32'hA5000000, 1, -1, 0);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t5_ser_zero", {28'd0, ser_data, ser_valid, ser_sof, ser_eof}, 32'd0);
      checkOutput("t5_busy", {31'd0, busy}, 32'd0);
      checkOutput("t5_ready_in_rst", {31'd0, s_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      logOn = 1'b0;
      analyzeLog();
      checkOutput("t5_eof_cnt", eofCnt, 32'd0);
      checkOutput("t5_partial_len", vCnt, PRE_W + 4);
      checkOutput("t5_ready_after", {31'd0, s_ready}, 32'd1);
      runFrame(32'hA5000000, 1, -1, 0);
      checkOutput("t5_len", vCnt, refA5Cnt);
      checkOutput("t5_bits", vBits[31:0], refA5[31:0]);

      $display("[TB] parity word 07");
      runFrame(32'h07000000, 1, -1, 0);
      pay = vBits >> PAR_EN;
      checkOutput("t6_len", vCnt, PRE_W + 8 + PAR_EN);
      checkOutput("t6_eof_pos", eofPos, PRE_W + 7 + PAR_EN);
      checkOutput("t6_eof_cnt", eofCnt, 32'd1);
      checkOutput("t6_last_bit", {31'd0, vBits[0]}, (PAR_EN != 0) ? 32'd1 : 32'd0);
      checkOutput("t6_payload", {24'd0, pay[7:0]}, 32'hC2);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
